// File: rtl/shiftx_deposit_ift_pkg.sv
// Shared IFT definitions: taint width, FSM state encoding
// and a constant clog2 helper for elaboration-time sizing.
package ift_pkg;

  localparam int TAINT_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shiftx_deposit_ift_lane.sv
// Combinational deposit of one D_WIDTH slice into the accumulator.
// Ports: acc_i/d_i/b_i in; acc_o next accumulator, oor_o dropped-bit flag.
module shiftx_deposit_lane
  import ift_pkg::*;
#(
  parameter int W_WIDTH  = 8,
  parameter int D_WIDTH  = 2,
  parameter int B_WIDTH  = 3,
  parameter int B_SIGNED = 0
) (
  input  logic [W_WIDTH-1:0] acc_i,
  input  logic [D_WIDTH-1:0] d_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic [W_WIDTH-1:0] acc_o,
  output logic               oor_o
);

  localparam int CW = clog2(W_WIDTH + D_WIDTH);
  localparam int PW = ((B_WIDTH > CW) ? B_WIDTH : CW) + 2;
  localparam logic signed [PW-1:0] WLIM = PW'(W_WIDTH);

  logic                 ext;
  logic signed [PW-1:0] off;
  logic signed [PW-1:0] p;

  // Two guard bits keep off+i from wrapping for any offset.
  assign ext = (B_SIGNED != 0) ? b_i[B_WIDTH-1] : 1'b0;
  assign off = {{(PW-B_WIDTH){ext}}, b_i};

  always_comb begin
    acc_o = acc_i;
    oor_o = 1'b0;
    p     = '0;
    for (int i = 0; i < D_WIDTH; i++) begin
      p = off + PW'(i);
      if (p[PW-1] || (p >= WLIM)) begin
        oor_o = 1'b1;
      end else begin
        for (int j = 0; j < W_WIDTH; j++) begin
          if (p == PW'(j)) acc_o[j] = d_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/shiftx_deposit_ift.sv
// Taint-tracked slice deposit packer with valid/ready in and out.
// Ports: CLK/ARST_N, IN_* beat side, OUT_* word side, Y/Y_t/ERR/CNT.
module shiftx_deposit_ift
  import ift_pkg::*;
#(
  parameter int W_WIDTH  = 8,
  parameter int D_WIDTH  = 2,
  parameter int B_WIDTH  = 3,
  parameter int B_SIGNED = 0
) (
  input  logic               CLK,
  input  logic               ARST_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [D_WIDTH-1:0] D,
  input  logic [TAINT_W-1:0] D_t,
  input  logic [B_WIDTH-1:0] B,
  input  logic [TAINT_W-1:0] B_t,
  input  logic               LAST,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [W_WIDTH-1:0] Y,
  output logic [TAINT_W-1:0] Y_t,
  output logic               ERR,
  output logic [7:0]         CNT
);

  if (W_WIDTH < 1 || D_WIDTH < 1 || B_WIDTH < 1) begin : g_bad
    $error("shiftx_deposit_ift: widths must be >= 1");
  end

  state_e               state_q;
  logic [W_WIDTH-1:0]   acc_q;
  logic [W_WIDTH-1:0]   acc_d;
  logic [TAINT_W-1:0]   acc_t_q;
  logic                 err_q;
  logic                 oor;
  logic [7:0]           cnt_q;
  logic [7:0]           cnt_d;

  shiftx_deposit_lane #(
    .W_WIDTH  (W_WIDTH),
    .D_WIDTH  (D_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .B_SIGNED (B_SIGNED)
  ) u_lane (
    .acc_i (acc_q),
    .d_i   (D),
    .b_i   (B),
    .acc_o (acc_d),
    .oor_o (oor)
  );

  assign cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      acc_t_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (IN_VALID) begin
            acc_q   <= acc_d;
            acc_t_q <= acc_t_q | D_t | B_t;
            err_q   <= err_q | oor;
            cnt_q   <= cnt_d;
            if (LAST) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            acc_t_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign IN_READY  = (state_q == ACCUM);
  assign OUT_VALID = (state_q == HOLD);
  assign Y         = acc_q;
  assign Y_t       = acc_t_q;
  assign ERR       = err_q;
  assign CNT       = cnt_q;

endmodule

// File: tb/tb_shiftx_deposit_ift.sv
// Scoreboard bench for shiftx_deposit_ift (unsigned and signed-offset
// instances); expected words come from a bit-level model of the deposit.
module tb_shiftx_deposit_ift;

  typedef struct {
    logic [7:0]  y;
    logic [31:0] t;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  logic        CLK = 0;
  logic        ARST_N = 0;
  logic        IN_VALID = 0;
  logic        IN_READY;
  logic [1:0]  D = 0;
  logic [31:0] D_t = 0;
  logic [2:0]  B = 0;
  logic [31:0] B_t = 0;
  logic        LAST = 0;
  logic        OUT_VALID;
  logic        OUT_READY = 0;
  logic [7:0]  Y;
  logic [31:0] Y_t;
  logic        ERR;
  logic [7:0]  CNT;

  logic        s_in_valid = 0;
  logic        s_in_ready;
  logic [1:0]  s_d = 0;
  logic [2:0]  s_b = 0;
  logic        s_last = 0;
  logic        s_out_valid;
  logic        s_out_ready = 0;
  logic [7:0]  s_y;
  logic [31:0] s_yt;
  logic        s_err;
  logic [7:0]  s_cnt;
  logic [31:0] zero32 = 0;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];
  logic [7:0]  m_acc = 0;
  logic [31:0] m_t = 0;
  logic        m_err = 0;
  int          m_cnt = 0;

  always #5 CLK = ~CLK;

  shiftx_deposit_ift #(
    .W_WIDTH(8), .D_WIDTH(2), .B_WIDTH(3), .B_SIGNED(0)
  ) dut (
    .CLK(CLK), .ARST_N(ARST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D(D), .D_t(D_t), .B(B), .B_t(B_t), .LAST(LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Y(Y), .Y_t(Y_t), .ERR(ERR), .CNT(CNT)
  );

  shiftx_deposit_ift #(
    .W_WIDTH(8), .D_WIDTH(2), .B_WIDTH(3), .B_SIGNED(1)
  ) dut_s (
    .CLK(CLK), .ARST_N(ARST_N),
    .IN_VALID(s_in_valid), .IN_READY(s_in_ready),
    .D(s_d), .D_t(zero32), .B(s_b), .B_t(zero32), .LAST(s_last),
    .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready),
    .Y(s_y), .Y_t(s_yt), .ERR(s_err), .CNT(s_cnt)
  );

  task automatic model_clear();
    m_acc = 0; m_t = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_beat(input logic [1:0] d, input int off,
                            input logic [31:0] dt, input logic [31:0] bt,
                            input logic last);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      int p;
      p = off + i;
      if (p >= 0 && p < 8) m_acc[p] = d[i];
      else m_err = 1;
    end
    m_t = m_t | dt | bt;
    if (m_cnt < 255) m_cnt++;
    if (last) begin
      e.y = m_acc; e.t = m_t; e.err = m_err; e.cnt = 8'(m_cnt);
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic beat(input logic [1:0] d, input int b,
                      input logic [31:0] dt, input logic [31:0] bt,
                      input logic last);
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready got %b want 1", IN_READY);
    end
    IN_VALID = 1; D = d; B = 3'(b); D_t = dt; B_t = bt; LAST = last;
    model_beat(d, b, dt, bt, last);
    @(posedge CLK);
    #1;
    IN_VALID = 0; LAST = 0; D_t = 0; B_t = 0;
  endtask

  task automatic expect_word(input string name);
    exp_t e;
    int lat;
    lat = 0;
    @(negedge CLK);
    while (!OUT_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checks++;
    if (OUT_VALID !== 1'b1 || lat != 0) begin
      errors++;
      $display("FAIL %s_latency got valid=%b after %0d cycles want 1 after 0",
               name, OUT_VALID, lat);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard got empty queue want entry", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (Y !== e.y) begin
      errors++; $display("FAIL %s_Y got %h want %h", name, Y, e.y);
    end
    checks++;
    if (Y_t !== e.t) begin
      errors++; $display("FAIL %s_Y_t got %h want %h", name, Y_t, e.t);
    end
    checks++;
    if (ERR !== e.err) begin
      errors++; $display("FAIL %s_ERR got %b want %b", name, ERR, e.err);
    end
    checks++;
    if (CNT !== e.cnt) begin
      errors++; $display("FAIL %s_CNT got %0d want %0d", name, CNT, e.cnt);
    end
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++; $display("FAIL %s_hold_ready got %b want 0", name, IN_READY);
    end
    OUT_READY = 1;
    @(posedge CLK);
    #1;
    OUT_READY = 0;
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, IN_READY, Y, Y_t, ERR, CNT} !== {1'b0, 1'b1, 8'h0, 32'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL %s_after_hs got v=%b r=%b Y=%h Yt=%h E=%b C=%0d want 0 1 00 0 0 0",
               name, OUT_VALID, IN_READY, Y, Y_t, ERR, CNT);
    end
  endtask

  task automatic test_reset();
    ARST_N = 0;
    #12;
    checks++;
    if ({IN_READY, OUT_VALID, Y, Y_t, ERR, CNT} !== {1'b1, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset got r=%b v=%b Y=%h Yt=%h E=%b C=%0d want 1 0 00 0 0 0",
               IN_READY, OUT_VALID, Y, Y_t, ERR, CNT);
    end
    @(negedge CLK);
    ARST_N = 1;
  endtask

  task automatic test_basic_pack();
    beat(2'b11, 0, 0, 0, 0);
    beat(2'b10, 4, 0, 0, 1);
    expect_word("basic");
  endtask

  task automatic test_overlap();
    beat(2'b11, 6, 0, 0, 0);
    beat(2'b01, 6, 0, 0, 0);
    beat(2'b11, 7, 0, 0, 1);
    expect_word("overlap");
  endtask

  task automatic test_taint();
    beat(2'b01, 1, 32'h1, 32'h0, 0);
    beat(2'b10, 3, 32'h0, 32'h100, 1);
    expect_word("taint");
    beat(2'b11, 2, 0, 0, 1);
    expect_word("taint_clean");
  endtask

  task automatic test_backpressure();
    logic [7:0]  y0;
    logic [31:0] t0;
    logic        e0;
    logic [7:0]  c0;
    beat(2'b01, 5, 32'h40, 32'h0, 0);
    beat(2'b11, 7, 32'h0, 32'h8, 1);
    @(negedge CLK);
    y0 = Y; t0 = Y_t; e0 = ERR; c0 = CNT;
    IN_VALID = 1; D = 2'b11; B = 3'd0; LAST = 1; D_t = 32'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if ({Y, Y_t, ERR, CNT, IN_READY, OUT_VALID} !== {y0, t0, e0, c0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_stable%0d got Y=%h Yt=%h E=%b C=%0d r=%b v=%b want %h %h %b %0d 0 1",
                 k, Y, Y_t, ERR, CNT, IN_READY, OUT_VALID, y0, t0, e0, c0);
      end
    end
    IN_VALID = 0; LAST = 0; D_t = 0;
    expect_word("bp");
  endtask

  task automatic test_cnt_saturate();
    for (int k = 0; k < 260; k++) beat(2'b10, k % 7, 0, 0, 0);
    beat(2'b01, 0, 0, 0, 1);
    expect_word("cnt_sat");
  endtask

  task automatic test_reset_mid();
    beat(2'b11, 1, 32'h2, 0, 0);
    beat(2'b11, 6, 0, 32'h4, 0);
    @(negedge CLK);
    #2;
    ARST_N = 0;
    #1;
    checks++;
    if ({Y, Y_t, ERR, CNT, IN_READY, OUT_VALID} !== {8'h0, 32'h0, 1'b0, 8'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got Y=%h Yt=%h E=%b C=%0d r=%b v=%b want 00 0 0 0 1 0",
               Y, Y_t, ERR, CNT, IN_READY, OUT_VALID);
    end
    model_clear();
    @(negedge CLK);
    ARST_N = 1;
    beat(2'b01, 2, 0, 0, 1);
    expect_word("after_reset");
  endtask

  task automatic test_signed();
    int lat;
    exp_t e;
    model_clear();
    @(negedge CLK);
    s_in_valid = 1; s_d = 2'b11; s_b = 3'b111; s_last = 1;
    model_beat(2'b11, -1, 0, 0, 1);
    @(posedge CLK);
    #1;
    s_in_valid = 0; s_last = 0;
    lat = 0;
    @(negedge CLK);
    while (!s_out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if ({s_out_valid, s_y, s_err, s_cnt} !== {1'b1, e.y, e.err, e.cnt} || lat != 0) begin
      errors++;
      $display("FAIL signed got v=%b Y=%h E=%b C=%0d lat=%0d want 1 %h %b %0d 0",
               s_out_valid, s_y, s_err, s_cnt, lat, e.y, e.err, e.cnt);
    end
    s_out_ready = 1;
    @(posedge CLK);
    #1;
    s_out_ready = 0;
    @(negedge CLK);
    checks++;
    if ({s_out_valid, s_y, s_err} !== {1'b0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL signed_hs got v=%b Y=%h E=%b want 0 00 0", s_out_valid, s_y, s_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_overlap();
    test_taint();
    test_backpressure();
    test_signed();
    test_cnt_saturate();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
